// File: rtl/float_div.sv
// float_div: iterative single-precision divider, radix-2 restoring mantissa division with round-to-nearest-even.
module float_div (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [31:0] dout,
    output logic        dout_valid
);
    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [24:0] r_q, r_d;
    logic [25:0] q_q, q_d;
    logic [23:0] m2_q, m2_d;
    logic [9:0]  e_q, e_d;
    logic        sign_q, sign_d, z1_q, z1_d, z2_q, z2_d;
    logic [31:0] dout_q, dout_d;
    logic        dv_q, dv_d;
    logic        ge, rnd, stk;
    logic [23:0] diff, mant_r;
    logic [22:0] mant;
    logic [9:0]  exp_n, exp_f;
    logic [31:0] res;
    always_comb begin
        ge     = r_q >= {1'b0, m2_q};
        diff   = r_q[23:0] - m2_q;
        mant   = q_q[25] ? q_q[24:2] : q_q[23:1];
        rnd    = q_q[25] ? q_q[1] : q_q[0];
        stk    = (q_q[25] & q_q[0]) | (r_q != 25'd0);
        exp_n  = q_q[25] ? e_q : e_q - 10'd1;
        mant_r = {1'b0, mant} + {23'd0, rnd & (stk | mant[0])};
        // A carry out of the fraction leaves mant_r[22:0] zero, so only the exponent moves.
        exp_f  = exp_n + {9'd0, mant_r[23]};
        res    = z2_q ? {sign_q, 8'hFF, 23'h0} :
                 z1_q ? 32'h0 :
                 ($signed(exp_f) >= 10'sd255) ? {sign_q, 8'hFF, 23'h0} :
                 ($signed(exp_f) <= 10'sd0) ? 32'h0 :
                 {sign_q, exp_f[7:0], mant_r[22:0]};
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        m2_d    = m2_q;
        e_d     = e_q;
        sign_d  = sign_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        case (state_q)
            IDLE: if (din_valid) begin
                state_d = DIV;
                cnt_d   = 5'd0;
                r_d     = {2'b01, din1[22:0]};
                q_d     = 26'd0;
                m2_d    = {1'b1, din2[22:0]};
                e_d     = {2'b0, din1[30:23]} - {2'b0, din2[30:23]} + 10'd127;
                sign_d  = din1[31] ^ din2[31];
                z1_d    = din1[30:23] == 8'd0;
                z2_d    = din2[30:23] == 8'd0;
            end
            DIV: begin
                r_d   = ge ? {diff, 1'b0} : {r_q[23:0], 1'b0};
                q_d   = {q_q[24:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) state_d = NORM;
            end
            NORM: begin
                dout_d  = res;
                dv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            r_q     <= 25'd0;
            q_q     <= 26'd0;
            m2_q    <= 24'd0;
            e_q     <= 10'd0;
            sign_q  <= 1'b0;
            z1_q    <= 1'b0;
            z2_q    <= 1'b0;
            dout_q  <= 32'h0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            m2_q    <= m2_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end
    assign din_ready  = state_q == IDLE;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
endmodule

// File: tb/tb_float_div.sv
// tb_float_div: randomized and directed checks of float_div against a real-arithmetic reference model.
module tb_float_div;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] din1 = 32'h0, din2 = 32'h0;
    logic        din_valid = 1'b0;
    logic        din_ready, dout_valid;
    logic [31:0] dout;
    int          n_tests = 0, n_fail = 0;

    float_div dut (
        .clk(clk), .nrst(nrst), .din1(din1), .din2(din2), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    // Exact quotient via double division; double rounding to single is innocuous for division.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [63:0] da, db, dq;
        real         rq;
        int          e;
        logic [23:0] m;
        logic [28:0] rest;
        s = a[31] ^ b[31];
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'h0};
        if (a[30:23] == 8'd0) return 32'h0;
        da = {1'b0, {3'b0, a[30:23]} + 11'd896, a[22:0], 29'd0};
        db = {1'b0, {3'b0, b[30:23]} + 11'd896, b[22:0], 29'd0};
        rq = $bitstoreal(da) / $bitstoreal(db);
        dq = $realtobits(rq);
        e = int'(dq[62:52]) - 896;
        m = {1'b0, dq[51:29]};
        rest = dq[28:0];
        if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && m[0])) m = m + 24'd1;
        if (m[23]) e = e + 1;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return 32'h0;
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] ex;
        ex = 8'($urandom_range(180, 70));
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res, output int lat);
        @(negedge clk);
        din1 = a; din2 = b; din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        lat = 0;
        res = 32'hxxxx_xxxx;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (dout_valid) begin
                res = dout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dout !== 32'h0 || dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: dout=%h valid=%b ready=%b, want 0/0/1", dout, dout_valid, din_ready);
        end
        @(negedge clk) nrst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int lat, bad_ready, bad_valid;
        @(negedge clk);
        din1 = 32'h40C00000; din2 = 32'h40000000; din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        bad_ready = 0; bad_valid = 0;
        for (int k = 1; k <= 27; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (din_ready !== 1'b0) bad_ready++;
            if (dout_valid !== 1'b0) bad_valid++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bad_ready != 0 || bad_valid != 0) begin
            n_fail++;
            $display("FAIL busy_window: ready_high=%0d early_valid=%0d, want 0/0", bad_ready, bad_valid);
        end
        n_tests++;
        if (dout_valid !== 1'b1 || dout !== 32'h40400000 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL 6/2: dout=%h valid=%b ready=%b, want 40400000/1/1", dout, dout_valid, din_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (dout_valid !== 1'b0 || dout !== 32'h40400000) begin
            n_fail++;
            $display("FAIL pulse_hold: valid=%b dout=%h, want 0/40400000", dout_valid, dout);
        end
        run_op(32'h3F800000, 32'h40400000, res, lat);
        n_tests++;
        if (res !== 32'h3EAAAAAB || lat != 27) begin
            n_fail++;
            $display("FAIL 1/3: dout=%h lat=%0d, want 3EAAAAAB/27", res, lat);
        end
        run_op(32'hBF800000, 32'h40800000, res, lat);
        n_tests++;
        if (res !== 32'hBE800000 || lat != 27) begin
            n_fail++;
            $display("FAIL -1/4: dout=%h lat=%0d, want BE800000/27", res, lat);
        end
    endtask

    task automatic test_specials();
        logic [31:0] a_t [4] = '{32'h3F800000, 32'h80000000, 32'h7F000000, 32'h00800000};
        logic [31:0] b_t [4] = '{32'h00000000, 32'h40000000, 32'h3E800000, 32'h40000000};
        logic [31:0] e_t [4] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 32'h00000000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(a_t[i], b_t[i], res, lat);
            n_tests++;
            if (res !== e_t[i] || lat != 27) begin
                n_fail++;
                $display("FAIL special%0d %h/%h: dout=%h lat=%0d, want %h/27", i, a_t[i], b_t[i], res, lat, e_t[i]);
            end
        end
        run_op(32'h00000000, 32'h00000000, res, lat);
        n_tests++;
        if (res !== 32'h7F800000) begin
            n_fail++;
            $display("FAIL zero_by_zero: dout=%h, want 7F800000", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        int acc_q [$];
        int nres, acc, lim;
        logic [31:0] want;
        nres = 0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            din1 = rand_op(); din2 = rand_op(); din_valid = 1'b1;
            if (din_ready) begin
                exp_q.push_back(ref_div(din1, din2));
                acc_q.push_back(cyc);
            end
            @(posedge clk); #1;
            if (dout_valid) begin
                nres++;
                want = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
                acc = acc_q.size() > 0 ? acc_q.pop_front() : -100;
                n_tests++;
                if (dout !== want || cyc - acc != 27 || din_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b%0d: dout=%h lat=%0d ready=%b, want %h/27/1", nres, dout, cyc - acc, din_ready, want);
                end
            end
        end
        @(negedge clk) din_valid = 1'b0;
        lim = 0;
        while (exp_q.size() > 0 && lim < 40) begin
            @(posedge clk); #1;
            lim++;
            if (dout_valid) begin
                nres++;
                want = exp_q.pop_front();
                n_tests++;
                if (dout !== want) begin
                    n_fail++;
                    $display("FAIL b2b_drain: dout=%h, want %h", dout, want);
                end
            end
        end
        n_tests++;
        if (nres != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: results=%0d pending=%0d, want 4/0", nres, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat, late;
        @(negedge clk);
        din1 = 32'h3F800000; din2 = 32'h40400000; din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) nrst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (dout !== 32'h0 || dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: dout=%h valid=%b ready=%b, want 0/0/1", dout, dout_valid, din_ready);
        end
        @(negedge clk) nrst = 1'b1;
        late = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (dout_valid) late++;
        end
        n_tests++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL late_pulse: pulses=%0d, want 0", late);
        end
        run_op(32'h40C00000, 32'h40000000, res, lat);
        n_tests++;
        if (res !== 32'h40400000 || lat != 27) begin
            n_fail++;
            $display("FAIL after_reset: dout=%h lat=%0d, want 40400000/27", res, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, want;
        int lat;
        for (int i = 0; i < 1500; i++) begin
            a = rand_op(); b = rand_op();
            want = ref_div(a, b);
            run_op(a, b, res, lat);
            n_tests++;
            if (res !== want || lat != 27) begin
                n_fail++;
                $display("FAIL rand%0d %h/%h: dout=%h lat=%0d, want %h/27", i, a, b, res, lat, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
